// File: rtl/ctrl_pkt_gen_pkg.sv
// Shared constants for the control-packet generator: header layout, table IDs,
// FSM encoding and a helper that assembles the 48-bit header word.
package ctrl_pkt_gen_pkg;

  localparam logic [15:0] CTRL_MAGIC    = 16'hF1F2;
  localparam logic [15:0] HDR_TUSER_LEN = 16'd128;

  localparam logic [3:0] MOD_KEY_OFF  = 4'd0;
  localparam logic [3:0] MOD_KEY_MASK = 4'd1;
  localparam logic [3:0] MOD_CAM      = 4'd2;
  localparam logic [3:0] MOD_ACT_RAM  = 4'd3;

  localparam int HDR_W          = 48;
  localparam int HDR_MAGIC_LSB  = 0;
  localparam int HDR_STAGE_LSB  = 16;
  localparam int HDR_MODULE_LSB = 20;
  localparam int HDR_INDEX_LSB  = 24;
  localparam int HDR_SEQ_LSB    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  function automatic logic [HDR_W-1:0] ctrl_hdr(input logic [3:0]  stage_id,
                                                 input logic [3:0]  module_id,
                                                 input logic [7:0]  index,
                                                 input logic [15:0] seq);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB  +: 16] = CTRL_MAGIC;
    h[HDR_STAGE_LSB  +: 4]  = stage_id;
    h[HDR_MODULE_LSB +: 4]  = module_id;
    h[HDR_INDEX_LSB  +: 8]  = index;
    h[HDR_SEQ_LSB    +: 16] = seq;
    return h;
  endfunction

endpackage

// File: rtl/ctrl_pkt_gen_if.sv
// Request side and control-stream side of the packet generator.
// master = requester/stream sink, slave = the generator.
interface ctrl_pkt_gen_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_stage_id;
  logic [3:0]        req_module_id;
  logic [7:0]        req_index;
  logic [DATA_W-1:0] req_data;

  logic [DATA_W-1:0]   c_m_axis_tdata;
  logic [USER_W-1:0]   c_m_axis_tuser;
  logic [DATA_W/8-1:0] c_m_axis_tkeep;
  logic                c_m_axis_tvalid;
  logic                c_m_axis_tlast;

  modport master (
    output req_valid, req_stage_id, req_module_id, req_index, req_data,
    input  req_ready,
    input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
  );

  modport slave (
    input  req_valid, req_stage_id, req_module_id, req_index, req_data,
    output req_ready,
    output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
  );
endinterface

// File: rtl/ctrl_req_fifo.sv
// First-word-fall-through request FIFO; a write while full is taken when the
// same cycle also reads, so occupancy holds and nothing is dropped.
module ctrl_req_fifo #(
  parameter int WIDTH = 528,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_ok, rd_ok;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; only entries below the pointers are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Turns table-write requests into two-beat control packets (header + payload)
// with a mandatory idle cycle between packets; bad stage IDs are counted and dropped.
module ctrl_pkt_gen
  import ctrl_pkt_gen_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH           = 4,
  parameter int NUM_STAGES           = 5
) (
  input  logic           axis_clk,
  input  logic           aresetn,
  ctrl_pkt_gen_if.slave  bus,
  output logic [15:0]    err_cnt
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = DW / 8;
  localparam int EW = 16 + DW;

  logic [EW-1:0] fifo_wr_data, fifo_rd_data;
  logic          fifo_full, fifo_empty, push, pop;

  logic [3:0]    head_stage, head_module;
  logic [7:0]    head_index;
  logic [DW-1:0] head_data;
  logic          stage_ok;

  state_e        state_q, state_d;
  logic [15:0]   seq_q, seq_d, err_q, err_d;
  logic [DW-1:0] dat_q, dat_d, tdata_q, tdata_d;
  logic [UW-1:0] tuser_q, tuser_d;
  logic [KW-1:0] tkeep_q, tkeep_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d;

  assign bus.req_ready = !fifo_full;
  assign push          = bus.req_valid && !fifo_full;
  assign fifo_wr_data  = {bus.req_stage_id, bus.req_module_id, bus.req_index, bus.req_data};
  assign {head_stage, head_module, head_index, head_data} = fifo_rd_data;
  assign stage_ok      = int'(head_stage) < NUM_STAGES;

  ctrl_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (axis_clk),
    .rst_n   (aresetn),
    .wr_en   (push),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stream outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    err_d    = err_q;
    dat_d    = dat_q;
    pop      = 1'b0;
    tdata_d  = '0;
    tuser_d  = '0;
    tkeep_d  = '0;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (stage_ok) begin
            state_d              = ST_HDR;
            dat_d                = head_data;
            tdata_d[HDR_W-1:0]   = ctrl_hdr(head_stage, head_module, head_index, seq_q);
            tuser_d[15:0]        = HDR_TUSER_LEN;
            tkeep_d              = '1;
            tvalid_d             = 1'b1;
          end else if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end
        end
      end
      ST_HDR: begin
        state_d  = ST_DATA;
        tdata_d  = dat_q;
        tkeep_d  = '1;
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
      end
      ST_DATA: begin
        state_d = ST_GAP;
        seq_d   = seq_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      seq_q    <= '0;
      err_q    <= '0;
      dat_q    <= '0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign bus.c_m_axis_tdata  = tdata_q;
  assign bus.c_m_axis_tuser  = tuser_q;
  assign bus.c_m_axis_tkeep  = tkeep_q;
  assign bus.c_m_axis_tvalid = tvalid_q;
  assign bus.c_m_axis_tlast  = tlast_q;
  assign err_cnt             = err_q;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Scoreboard bench for ctrl_pkt_gen: a timing model predicts every beat and its
// cycle; a monitor pops and compares whenever the stream is valid.
module tb_ctrl_pkt_gen;
  import ctrl_pkt_gen_pkg::*;

  localparam int DW    = 512;
  localparam int UW    = 128;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int NSTG  = 5;

  logic        axis_clk = 1'b0;
  logic        aresetn  = 1'b0;
  logic [15:0] err_cnt;

  ctrl_pkt_gen_if #(.DATA_W(DW), .USER_W(UW)) bus ();

  ctrl_pkt_gen #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .FIFO_DEPTH          (DEPTH),
    .NUM_STAGES          (NSTG)
  ) dut (
    .axis_clk(axis_clk),
    .aresetn (aresetn),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  int          pop_q[$];
  int          cyc       = 0;
  int          next_free = 0;
  int          n_tests   = 0;
  int          n_fail    = 0;
  logic [15:0] m_seq     = '0;
  logic [15:0] m_err     = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted request is popped at the first cycle the
  // generator is free; a packet occupies 3 cycles, a rejected request 1.
  initial begin : model
    logic          s_rst, s_acc, s_rdy;
    logic [3:0]    s_stage, s_mod;
    logic [7:0]    s_idx;
    logic [DW-1:0] s_data, h;
    int            p;
    forever begin
      @(negedge axis_clk);
      s_rst   = aresetn;
      s_rdy   = bus.req_ready;
      s_acc   = bus.req_valid && bus.req_ready;
      s_stage = bus.req_stage_id;
      s_mod   = bus.req_module_id;
      s_idx   = bus.req_index;
      s_data  = bus.req_data;
      @(posedge axis_clk);
      cyc++;
      if (s_rst) begin
        while (pop_q.size() != 0 && pop_q[0] < cyc) void'(pop_q.pop_front());
        chk("req_ready", DW'(s_rdy), DW'(pop_q.size() != DEPTH));
        if (s_acc) begin
          p = (cyc + 1 > next_free) ? cyc + 1 : next_free;
          pop_q.push_back(p);
          if (int'(s_stage) < NSTG) begin
            h = '0;
            h[15:0]  = 16'hF1F2;
            h[19:16] = s_stage;
            h[23:20] = s_mod;
            h[31:24] = s_idx;
            h[47:32] = m_seq;
            exp_q.push_back('{p, h, UW'(128), 1'b0});
            exp_q.push_back('{p + 1, s_data, UW'(0), 1'b1});
            m_seq++;
            next_free = p + 3;
          end else begin
            next_free = p + 1;
            if (m_err != 16'hFFFF) m_err++;
          end
        end
      end
    end
  end

  initial begin : monitor
    beat_t         e;
    logic [KW-1:0] ones;
    ones = '1;
    forever begin
      @(negedge axis_clk);
      if (bus.c_m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", DW'(bus.c_m_axis_tvalid), DW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat_cycle", DW'(cyc), DW'(e.cyc));
          chk("tdata", bus.c_m_axis_tdata, e.tdata);
          chk("tuser", DW'(bus.c_m_axis_tuser), DW'(e.tuser));
          chk("tkeep", DW'(bus.c_m_axis_tkeep), DW'(ones));
          chk("tlast", DW'(bus.c_m_axis_tlast), DW'(e.last));
        end
      end else begin
        chk("idle_zero", DW'({bus.c_m_axis_tlast, bus.c_m_axis_tuser, bus.c_m_axis_tkeep})
                         | bus.c_m_axis_tdata, DW'(0));
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          chk("missing_beat", DW'(0), DW'(1));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // All stimulus changes 1 time unit after a rising edge.
  task automatic send(input logic [3:0] st, input logic [3:0] md, input logic [7:0] ix,
                      input logic [DW-1:0] dt);
    int n;
    bus.req_valid     = 1'b1;
    bus.req_stage_id  = st;
    bus.req_module_id = md;
    bus.req_index     = ix;
    bus.req_data      = dt;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge axis_clk); #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", DW'(bus.req_ready), DW'(1));
    @(posedge axis_clk); #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin @(posedge axis_clk); #1; end
  endtask

  task automatic drain();
    int n;
    bus.req_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || cyc < next_free + 1) && n < 1000) begin
      @(posedge axis_clk); #1;
      n++;
    end
    if (n >= 1000) chk("drain_timeout", DW'(exp_q.size()), DW'(0));
    chk("err_cnt", DW'(err_cnt), DW'(m_err));
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    bus.req_valid = 1'b0;
    exp_q.delete();
    pop_q.delete();
    next_free = 0;
    m_seq     = '0;
    m_err     = '0;
    #1;
    chk("rst_tvalid", DW'(bus.c_m_axis_tvalid), DW'(0));
    chk("rst_ready", DW'(bus.req_ready), DW'(1));
    chk("rst_err_cnt", DW'(err_cnt), DW'(0));
    repeat (2) @(posedge axis_clk);
    #1 aresetn = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int n;
    bus.req_valid     = 1'b0;
    bus.req_stage_id  = '0;
    bus.req_module_id = '0;
    bus.req_index     = '0;
    bus.req_data      = '0;
    @(posedge axis_clk); #1;
    do_reset();

    // Single directed request: header 48'h0000_0532_F1F2, A5 payload
    send(4'd2, MOD_ACT_RAM, 8'h05, {64{8'hA5}});
    drain();

    // Back-to-back burst that overfills the FIFO and exercises push+pop when near full
    for (int i = 0; i < 8; i++) send(4'(i % NSTG), MOD_KEY_OFF, 8'(i), rnd_data());
    drain();

    // Rejected stage 7 must not consume a sequence number
    do_reset();
    send(4'd7, MOD_CAM, 8'h11, rnd_data());
    send(4'd0, MOD_KEY_MASK, 8'h22, rnd_data());
    drain();

    // Randomised mix of valid/invalid stages and gaps
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 8)), 4'($urandom_range(0, 3)), 8'($urandom()), rnd_data());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 4));
    end
    drain();

    // Sequence wrap: jump the counter to FFFF, next headers carry FFFF then 0000
    force dut.seq_q = 16'hFFFF;
    @(posedge axis_clk); #1;
    release dut.seq_q;
    m_seq = 16'hFFFF;
    send(4'd1, MOD_CAM, 8'hA0, rnd_data());
    send(4'd3, MOD_CAM, 8'hA1, rnd_data());
    drain();

    // Reset while the payload beat is on the bus, with requests still queued
    send(4'd4, MOD_KEY_OFF, 8'h30, rnd_data());
    send(4'd4, MOD_KEY_OFF, 8'h31, rnd_data());
    send(4'd4, MOD_KEY_OFF, 8'h32, rnd_data());
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.c_m_axis_tlast && n < 50) begin
      @(posedge axis_clk); #1;
      n++;
    end
    if (n >= 50) chk("data_beat_timeout", DW'(bus.c_m_axis_tlast), DW'(1));
    do_reset();
    idle(12);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pkt_gen.md
CTRL_PKT_GEN -- requirements
Module: ctrl_pkt_gen

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 512, meaning control-stream data width.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, meaning control-stream tuser width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning request FIFO entries (power of 2).
REQ-004 SHALL have parameter NUM_STAGES, default 5, meaning valid stage IDs 0..NUM_STAGES-1.
REQ-005 SHALL have port axis_clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit, meaning a write request is offered.
REQ-008 SHALL have port req_ready, output, 1 bit, meaning the FIFO is not full.
REQ-009 SHALL have port req_stage_id, input, 4 bits, meaning the target stage.
REQ-010 SHALL have port req_module_id, input, 4 bits, meaning the target table: 0 key offset, 1 key mask, 2 CAM, 3 action RAM.
REQ-011 SHALL have port req_index, input, 8 bits, meaning the table entry index.
REQ-012 SHALL have port req_data, input, C_S_AXIS_DATA_WIDTH bits, meaning the entry payload.
REQ-013 SHALL have port c_m_axis_tdata/tuser/tkeep/tvalid/tlast, output, widths DATA/TUSER/DATA/8/1/1, meaning the control stream; it has no tready.
REQ-014 SHALL have port err_cnt, output, 16 bits, meaning the count of rejected requests.

Function
REQ-015 SHALL accept a request on each rising edge where req_valid and req_ready are both 1; req_ready SHALL equal (FIFO occupancy != FIFO_DEPTH).
REQ-016 SHALL run FSM states IDLE, HDR, DATA, GAP; reset state IDLE.
REQ-017 IDLE/GAP with FIFO non-empty SHALL pop one entry; valid stage ID -> HDR; invalid -> IDLE and err_cnt+1, saturating at 16'hFFFF.
REQ-018 IDLE/GAP with FIFO empty -> IDLE; HDR -> DATA; DATA -> GAP unconditionally.
REQ-019 HDR beat SHALL drive tdata[15:0]=16'hF1F2, [19:16]=stage_id, [23:20]=module_id, [31:24]=index, [47:32]=seq, remaining bits 0, tkeep all ones, tuser[15:0]=16'd128 with other bits 0, tvalid=1, tlast=0.
REQ-020 DATA beat SHALL drive tdata=req_data, tkeep all ones, tuser=0, tvalid=1, tlast=1.
REQ-021 In IDLE/GAP, tvalid, tlast, tdata, tkeep and tuser SHALL all be 0, giving at least one idle cycle between packets.
REQ-022 All c_m_axis outputs SHALL be registered.
REQ-023 Latency SHALL be: request accepted at edge N -> HDR beat at N+2 and DATA beat at N+3; back-to-back packets SHALL be emitted every 3 cycles.
REQ-024 The 16-bit seq counter SHALL start at 0, increment once per emitted packet after its DATA beat, wrap FFFF->0, and not advance on rejected requests.
REQ-025 A push and a pop in the same cycle SHALL leave occupancy unchanged and drop no data, including when the FIFO is full.
REQ-026 Emission order SHALL equal acceptance order.

Reset
REQ-027 Assertion of aresetn SHALL immediately clear FSM, FIFO pointers/occupancy, seq and err_cnt; all c_m_axis outputs SHALL read 0 and req_ready SHALL read 1 after reset.
REQ-028 A reset during HDR or DATA SHALL abort the packet; no tlast beat is emitted, and queued requests are discarded.

Structure
REQ-029 The shared package SHALL hold CTRL_MAGIC (16'hF1F2), the module-ID constants, the header field offsets, and the FSM state encoding.
REQ-030 The request FIFO SHALL be one sub-module, ctrl_req_fifo, with width 16+C_S_AXIS_DATA_WIDTH and depth FIFO_DEPTH.

Verification
REQ-031 Single request (stage 2, module 3, index 8'h05, data 512'hA5..A5) -> header tdata[47:0]=48'h0000_0532_F1F2 at N+2, data beat with tlast=1 at N+3, err_cnt=0.
REQ-032 Six requests offered back-to-back -> req_ready deasserts after the FIFO fills; all six packets are emitted in order with seq 0..5 and 3-cycle spacing.
REQ-033 Request with stage_id=7 -> no tvalid, err_cnt=1, and the next valid packet uses seq 0.
REQ-034 Preload seq=16'hFFFF via 65535 packets, then emit 2 more -> header seq fields are FFFF then 0000.
REQ-035 Assert aresetn low during the DATA beat -> tvalid=0 in the same cycle, req_ready=1, err_cnt=0, and the FIFO is empty.
REQ-036 FIFO full with a simultaneous push and pop -> occupancy stays 4 and the pushed entry is emitted fifth.
